// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory I/D port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAw      = 32;
  localparam int unsigned DefDw      = 32;
  localparam int unsigned StarveCntW = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating starvation counter: counts denied cycles of the fetch port up to Limit.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic                  at_limit_o,
  output logic [StarveCntW-1:0] cnt_o
);

  localparam logic [StarveCntW-1:0] LimitCnt = StarveCntW'(Limit);

  logic [StarveCntW-1:0] cnt_d, cnt_q;

  assign at_limit_o = (cnt_q == LimitCnt);
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and load/store (D) ports.
// D has priority; the starvation counter forces an I grant after STARVE_LIMIT denials.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = DefAw,
  parameter int unsigned DW           = DefDw,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  owner_t owner_d, owner_q;
  owner_t grant;
  logic   i_out_d, i_out_q;
  logic   d_out_d, d_out_q;
  logic   store_d, store_q;
  logic   i_elig, d_elig;
  logic   at_limit;
  logic [StarveCntW-1:0] starve_cnt;

  assign i_elig = i_req && !i_out_q;
  assign d_elig = d_req && !d_out_q;

  assign i_ack = (owner_q == OWN_I);
  assign d_ack = (owner_q == OWN_D);

  // Grant decision; reset holds the RAM idle.
  always_comb begin
    grant = OWN_NONE;
    if (!Rst) begin
      if (i_elig && d_elig) begin
        grant = at_limit ? OWN_I : OWN_D;
      end else if (i_elig) begin
        grant = OWN_I;
      end else if (d_elig) begin
        grant = OWN_D;
      end
    end
  end

  always_comb begin
    owner_d = grant;
    store_d = (grant == OWN_D) && d_we;
    i_out_d = i_out_q;
    d_out_d = d_out_q;
    if (i_ack) i_out_d = 1'b0;
    if (d_ack) d_out_d = 1'b0;
    if (grant == OWN_I) i_out_d = 1'b1;
    if (grant == OWN_D) d_out_d = 1'b1;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      owner_q <= OWN_NONE;
      store_q <= 1'b0;
      i_out_q <= 1'b0;
      d_out_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      store_q <= store_d;
      i_out_q <= i_out_d;
      d_out_q <= d_out_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (grant)
      OWN_I: begin
        mem_en   = 1'b1;
        mem_addr = i_addr;
      end
      OWN_D: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    i_rdata = i_ack ? mem_rdata : '0;
    d_rdata = (d_ack && !store_q) ? mem_rdata : '0;
  end

  arb_starve_counter #(
    .Limit(STARVE_LIMIT)
  ) u_starve (
    .clk_i      (clk),
    .rst_i      (Rst),
    .inc_i      (i_elig && (grant != OWN_I)),
    .clr_i      (grant == OWN_I),
    .at_limit_o (at_limit),
    .cnt_o      (starve_cnt)
  );

  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 2;

  logic          clk = 1'b0;
  logic          Rst;
  logic          i_req, i_ack;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .Rst      (Rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous RAM with a backdoor write port for preloading.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] rd_q;
  logic          bd_we;
  logic [7:0]    bd_addr;
  logic [DW-1:0] bd_data;
  assign mem_rdata = rd_q;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else rd_q <= ram[mem_addr[7:0]];
    end
  end

  function automatic logic [31:0] seed(int i);
    if (i == 16) return 32'h2002_0005;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    idle_inputs();
    next_cycle();
    Rst = 1'b0;
  endtask

  typedef struct {
    logic        rst, ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic        exp_en, exp_we;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the randomized run.
  logic [31:0] shadow [0:255];
  bit          m_i_pend, m_d_pend, m_iack, m_dack;
  logic [31:0] m_i_data, m_d_data;
  int          m_starve;
  bit          i_wait, d_wait;

  initial begin
    Rst   = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      bd_we = 1'b1; bd_addr = 8'(i); bd_data = seed(i);
      shadow[i] = seed(i);
      next_cycle();
    end
    bd_we = 1'b0;

    // ---------------- vector table: grant/mux from a clean state ----------------
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,
                1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h0,  32'h0,
                1'b1, 1'b0, 32'h21, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h33, 32'h5555,
                1'b1, 1'b0, 32'h33, 32'h5555};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h34, 32'hCAFE_F00D,
                1'b1, 1'b1, 32'h34, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h22, 32'h35, 32'h77,
                1'b1, 1'b0, 32'h35, 32'h77};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h22, 32'h36, 32'h99,
                1'b0, 1'b0, 32'h0, 32'h0};
    for (int v = 0; v < 6; v++) begin
      Rst = 1'b1;
      #1;
      Rst = vecs[v].rst;
      i_req = vecs[v].ireq; i_addr = vecs[v].iaddr;
      d_req = vecs[v].dreq; d_we = vecs[v].dwe;
      d_addr = vecs[v].daddr; d_wdata = vecs[v].dwdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_en", v), mem_en, vecs[v].exp_en);
      chk($sformatf("tbl%0d_mem_we", v), mem_we, vecs[v].exp_we);
      chk($sformatf("tbl%0d_mem_addr", v), mem_addr, vecs[v].exp_addr);
      chk($sformatf("tbl%0d_mem_wdata", v), mem_wdata, vecs[v].exp_wdata);
      chk($sformatf("tbl%0d_acks", v), {i_ack, d_ack}, 2'b00);
      next_cycle();
    end
    do_reset();

    // ---------------- reset with both requests pending ----------------
    Rst = 1'b1;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h41; d_we = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_acks", {i_ack, d_ack, mem_we}, 3'b000);
      next_cycle();
    end
    Rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_d_grant", {mem_en, mem_addr}, {1'b1, 32'h41});
    next_cycle();
    @(negedge clk);
    chk("rst_rel_d_ack", {d_ack, i_ack}, 2'b10);
    chk("rst_rel_d_rdata", d_rdata, seed(16'h41));
    chk("rst_rel_i_grant", {mem_en, mem_we, mem_addr}, {2'b10, 32'h10});
    next_cycle();
    d_req = 0; i_req = 0;
    @(negedge clk);
    chk("rst_rel_i_ack", {i_ack, d_ack}, 2'b10);
    chk("rst_rel_i_rdata", i_rdata, 32'h2002_0005);
    do_reset();

    // ---------------- lone fetch ----------------
    i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    chk("fetch_grant", {mem_en, mem_we, mem_addr}, {2'b10, 32'h10});
    next_cycle();
    i_req = 0;
    @(negedge clk);
    chk("fetch_ack", {i_ack, d_ack}, 2'b10);
    chk("fetch_rdata", i_rdata, 32'h2002_0005);

    // ---------------- store then load ----------------
    next_cycle();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_grant", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h40, 32'hDEAD_BEEF});
    next_cycle();
    @(negedge clk);
    chk("st_ack", {d_ack, mem_en}, 2'b10);
    chk("st_rdata", d_rdata, 32'h0);
    next_cycle();
    d_we = 0;
    @(negedge clk);
    chk("ld_grant", {mem_en, mem_we, mem_addr}, {2'b10, 32'h40});
    next_cycle();
    d_req = 0;
    @(negedge clk);
    chk("ld_ack", d_ack, 1'b1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    do_reset();

    // ---------------- continuous contention: D, I, D, I ... ----------------
    i_req = 1; i_addr = 32'h11; d_req = 1; d_addr = 32'h42; d_we = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("alt%0d_en", k), mem_en, 1'b1);
      chk($sformatf("alt%0d_addr", k), mem_addr, (k % 2 == 0) ? 32'h42 : 32'h11);
      chk($sformatf("alt%0d_starve_le1", k), 32'(dut.u_starve.cnt_q <= 4'd1), 32'd1);
      next_cycle();
    end
    do_reset();

    // ---------------- starvation override with D made always eligible ----------------
    i_req = 1; i_addr = 32'h12; d_req = 1; d_addr = 32'h43; d_we = 0;
    force dut.d_out_q = 1'b0;
    begin
      int first_i;
      first_i = -1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (first_i < 0 && mem_en && mem_addr == 32'h12) first_i = k;
        next_cycle();
      end
      chk("starve_i_grant_cycle", 32'(first_i), 32'd2);
    end
    @(negedge clk);
    chk("starve_cnt_cleared", 32'(dut.u_starve.cnt_q), 32'd0);
    chk("starve_i_ack", i_ack, 1'b1);
    release dut.d_out_q;
    next_cycle();
    do_reset();

    // ---------------- reset in the grant cycle of a fetch ----------------
    i_req = 1; i_addr = 32'h13;
    @(negedge clk);
    chk("midrst_grant", mem_en, 1'b1);
    Rst = 1'b1;
    i_req = 0;
    @(negedge clk);
    chk("midrst_no_ack0", i_ack, 1'b0);
    next_cycle();
    Rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_ack%0d", k + 1), i_ack, 1'b0);
      next_cycle();
    end
    i_req = 1;
    @(negedge clk);
    chk("midrst_regrant", {mem_en, mem_addr}, {1'b1, 32'h13});
    next_cycle();
    i_req = 0;
    @(negedge clk);
    chk("midrst_ack", i_ack, 1'b1);
    chk("midrst_rdata", i_rdata, seed(16'h13));
    do_reset();

    // ---------------- randomized traffic vs reference model ----------------
    m_i_pend = 0; m_d_pend = 0; m_iack = 0; m_dack = 0; m_starve = 0;
    m_i_data = '0; m_d_data = '0; i_wait = 0; d_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      bit e_iack, e_dack, i_el, d_el, gi, gd;
      logic [31:0] e_addr, e_wdata;
      // Requesters: hold until acked, then optionally issue a new access.
      if (!i_wait) begin
        i_req = ($urandom_range(0, 3) != 0);
        i_addr = {24'h0, 1'b1, 7'($urandom)};
        i_wait = i_req;
      end
      if (!d_wait) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = 1'($urandom);
        d_addr = {24'h0, 1'b1, 7'($urandom)};
        d_wdata = $urandom;
        d_wait = d_req;
      end
      @(negedge clk);
      if (i_wait && !i_req) $error("protocol: i_req dropped before ack");
      if (d_wait && !d_req) $error("protocol: d_req dropped before ack");
      e_iack = m_iack;
      e_dack = m_dack;
      i_el = i_req && !m_i_pend;
      d_el = d_req && !m_d_pend;
      gi = i_el && (!d_el || m_starve == LIM);
      gd = d_el && !gi;
      e_addr  = gi ? i_addr : (gd ? d_addr : 32'h0);
      e_wdata = gd ? d_wdata : 32'h0;
      chk("rnd_mem_en", mem_en, gi | gd);
      chk("rnd_mem_we", mem_we, gd & d_we);
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_wdata", mem_wdata, e_wdata);
      chk("rnd_i_ack", i_ack, e_iack);
      chk("rnd_d_ack", d_ack, e_dack);
      chk("rnd_i_rdata", i_rdata, e_iack ? m_i_data : 32'h0);
      chk("rnd_d_rdata", d_rdata, e_dack ? m_d_data : 32'h0);
      if (e_iack) begin m_i_pend = 0; i_wait = 0; end
      if (e_dack) begin m_d_pend = 0; d_wait = 0; end
      if (gi) begin
        m_i_pend = 1;
        m_i_data = shadow[i_addr[7:0]];
      end
      if (gd) begin
        m_d_pend = 1;
        m_d_data = d_we ? 32'h0 : shadow[d_addr[7:0]];
        if (d_we) shadow[d_addr[7:0]] = d_wdata;
      end
      if (gi) m_starve = 0;
      else if (i_el && m_starve < LIM) m_starve++;
      m_iack = gi;
      m_dack = gd;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
